ea_gen: RTL and testbench

//   Effective-address stage for the LC-3 datapath, fed by the ADDR2 select path.
//   Per accepted instruction it sign-extends the IR offset fields and selects ADDR2
//   (00 zero, 01 sext IR[5:0], 10 sext IR[8:0], 11 sext IR[10:0]).
//   It adds ADDR2 to ADDR1 (PC or BaseR), resolves LDI/STI indirection by a memory read,
//   and hands the final EA to the MAR/PC load logic over a valid/ready link.

---
 rtl/ea_gen.sv | 135 +++++++++++++
 tb/tb_ea_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ea_gen.sv
`default_nettype none
// ============================================================================
// Module   : ea_gen
// Brief    : LC-3 effective-address stage. Computes ADDR1 + ADDR2, resolves
//            LDI/STI pointer indirection over a memory read, and hands the
//            final EA on over a valid/ready link.
//            Optional user-mode range check enabled by macro ACV_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ea_gen #(
    parameter logic [15:0] ACV_LO = 16'h3000,
    parameter logic [15:0] ACV_HI = 16'hFE00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] ir,
    input  logic [15:0] pc,
    input  logic [15:0] base_r,
    input  logic        addr1_sel,
    input  logic [1:0]  addr2_sel,
    input  logic        indirect,
    input  logic        priv,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_ea,
    output logic        acv,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_ind_req = 2'd1;
    localparam logic [1:0] c_done    = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [15:0] r_ea;
    logic [15:0] w_ea_nxt;
    logic        r_acv;
    logic        w_acv_nxt;
    logic [15:0] w_addr1;
    logic [15:0] w_addr2;
    logic [15:0] w_sum;
    logic        w_accept;
    logic        w_acv_acc;
    logic        w_acv_ptr;

    assign w_addr1  = addr1_sel ? base_r : pc;
    assign w_sum    = w_addr1 + w_addr2;
    assign w_accept = (r_state == c_idle) && in_valid;

    always_comb begin
        w_addr2 = 16'h0000;
        case (addr2_sel)
            2'b01:   w_addr2 = {{10{ir[5]}}, ir[5:0]};
            2'b10:   w_addr2 = {{7{ir[8]}},  ir[8:0]};
            2'b11:   w_addr2 = {{5{ir[10]}}, ir[10:0]};
            default: w_addr2 = 16'h0000;
        endcase
    end

    // Opcode bits never feed the address path.
    wire w_unused_ir = &{1'b0, ir[15:11]};

`ifdef ACV_CHECK_EN
    logic r_priv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_priv <= 1'b0;
        else if (w_accept)
            r_priv <= priv;
    end

    assign w_acv_acc = priv   & ((w_sum < ACV_LO)     | (w_sum >= ACV_HI));
    assign w_acv_ptr = r_priv & ((mem_rdata < ACV_LO) | (mem_rdata >= ACV_HI));
`else
    assign w_acv_acc = 1'b0;
    assign w_acv_ptr = 1'b0;
    wire w_unused_acv = &{1'b0, priv, ACV_LO, ACV_HI};
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_ea_nxt    = r_ea;
        w_acv_nxt   = r_acv;
        case (r_state)
            c_idle: begin
                if (in_valid) begin
                    w_ea_nxt    = w_sum;
                    w_acv_nxt   = w_acv_acc;
                    // A violating pointer address is reported without being read.
                    w_state_nxt = (indirect && !w_acv_acc) ? c_ind_req : c_done;
                end
            end
            c_ind_req: begin
                if (mem_ack) begin
                    w_ea_nxt    = mem_rdata;
                    w_acv_nxt   = w_acv_ptr;
                    w_state_nxt = c_done;
                end
            end
            c_done: begin
                if (out_ready)
                    w_state_nxt = c_idle;
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_idle;
            r_ea    <= 16'h0000;
            r_acv   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ea    <= w_ea_nxt;
            r_acv   <= w_acv_nxt;
        end
    end

    assign in_ready  = (r_state == c_idle);
    assign out_valid = (r_state == c_done);
    assign mem_req   = (r_state == c_ind_req);
    assign mem_addr  = r_ea;
    assign out_ea    = r_ea;
    assign acv       = r_acv;

endmodule
`default_nettype wire

// File: tb/tb_ea_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ea_gen
// Brief    : Self-checking bench for ea_gen: table of direct EA vectors plus
//            hand-written indirection, back-pressure, reset and ACV sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ea_gen;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ir;
    logic [15:0] pc;
    logic [15:0] base_r;
    logic        addr1_sel;
    logic [1:0]  addr2_sel;
    logic        indirect;
    logic        priv;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ea;
    logic        acv;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    int r_pass  = 0;
    int r_total = 0;
    bit r_acv_en;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] pc;
        logic [15:0] base_r;
        logic        addr1_sel;
        logic [1:0]  addr2_sel;
        logic [15:0] exp_ea;
    } vec_t;

    vec_t vecs[7];

    ea_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ir        (ir),
        .pc        (pc),
        .base_r    (base_r),
        .addr1_sel (addr1_sel),
        .addr2_sel (addr2_sel),
        .indirect  (indirect),
        .priv      (priv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ea    (out_ea),
        .acv       (acv),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        r_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            r_pass++;
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a_pc, input logic ind, input logic pv);
        pc        = a_pc;
        addr1_sel = 1'b0;
        addr2_sel = 2'b00;
        ir        = 16'h0000;
        indirect  = ind;
        priv      = pv;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        indirect  = 1'b0;
    endtask

    initial begin
`ifdef ACV_CHECK_EN
        r_acv_en = 1'b1;
`else
        r_acv_en = 1'b0;
`endif
        vecs[0] = '{16'h21FF, 16'h3001, 16'h0000, 1'b0, 2'b10, 16'h3000};
        vecs[1] = '{16'h0020, 16'h0000, 16'h4000, 1'b1, 2'b01, 16'h3FE0};
        vecs[2] = '{16'h0001, 16'hFFFF, 16'h0000, 1'b0, 2'b10, 16'h0000};
        vecs[3] = '{16'hFFFF, 16'h1234, 16'h9999, 1'b0, 2'b00, 16'h1234};
        vecs[4] = '{16'h0400, 16'h3000, 16'h0000, 1'b0, 2'b11, 16'h2C00};
        vecs[5] = '{16'h03FF, 16'h5555, 16'h1000, 1'b1, 2'b11, 16'h13FF};
        vecs[6] = '{16'hFFDF, 16'h0100, 16'h0000, 1'b0, 2'b01, 16'h011F};

        rst_n = 1'b0; in_valid = 1'b0; ir = 16'h0; pc = 16'h0; base_r = 16'h0;
        addr1_sel = 1'b0; addr2_sel = 2'b00; indirect = 1'b0; priv = 1'b0;
        out_ready = 1'b1; mem_ack = 1'b0; mem_rdata = 16'h0;
        #12;
        chk("rst in_ready",  {15'h0, in_ready},  16'h1);
        chk("rst out_valid", {15'h0, out_valid}, 16'h0);
        chk("rst out_ea",    out_ea,             16'h0);
        chk("rst acv",       {15'h0, acv},       16'h0);
        chk("rst mem_req",   {15'h0, mem_req},   16'h0);
        chk("rst mem_addr",  mem_addr,           16'h0);
        rst_n = 1'b1;
        tick();

        // Direct vectors: out_valid one cycle after accept, then back to IDLE.
        for (int i = 0; i < 7; i++) begin
            ir = vecs[i].ir; pc = vecs[i].pc; base_r = vecs[i].base_r;
            addr1_sel = vecs[i].addr1_sel; addr2_sel = vecs[i].addr2_sel;
            indirect = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
            chk($sformatf("v%0d in_ready", i), {15'h0, in_ready}, 16'h1);
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d out_valid", i), {15'h0, out_valid}, 16'h1);
            chk($sformatf("v%0d out_ea", i), out_ea, vecs[i].exp_ea);
            chk($sformatf("v%0d mem_req", i), {15'h0, mem_req}, 16'h0);
            tick();
            chk($sformatf("v%0d idle", i), {15'h0, out_valid}, 16'h0);
        end

        // Indirect: ack on the third request cycle, then hold DONE for 5 cycles.
        out_ready = 1'b0;
        issue(16'h3010, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ind req%0d", k), {15'h0, mem_req}, 16'h1);
            chk($sformatf("ind addr%0d", k), mem_addr, 16'h3010);
            chk($sformatf("ind in_ready%0d", k), {15'h0, in_ready}, 16'h0);
            chk($sformatf("ind ovalid%0d", k), {15'h0, out_valid}, 16'h0);
            if (k == 2) begin
                mem_ack = 1'b1; mem_rdata = 16'h5000;
            end
            tick();
        end
        mem_ack = 1'b0;
        chk("ind out_valid", {15'h0, out_valid}, 16'h1);
        chk("ind out_ea", out_ea, 16'h5000);
        chk("ind req drop", {15'h0, mem_req}, 16'h0);

        pc = 16'h7777; indirect = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mem_ack = (k == 2); mem_rdata = 16'hDEAD;
            tick();
            chk($sformatf("hold ovalid%0d", k), {15'h0, out_valid}, 16'h1);
            chk($sformatf("hold ea%0d", k), out_ea, 16'h5000);
            chk($sformatf("hold in_ready%0d", k), {15'h0, in_ready}, 16'h0);
        end
        mem_ack = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("release ovalid", {15'h0, out_valid}, 16'h0);
        chk("release in_ready", {15'h0, in_ready}, 16'h1);
        chk("release ea", out_ea, 16'h5000);

        // Ack on the very first request cycle.
        issue(16'h4444, 1'b1, 1'b0);
        chk("ack1 req", {15'h0, mem_req}, 16'h1);
        mem_ack = 1'b1; mem_rdata = 16'h1357;
        tick();
        mem_ack = 1'b0;
        chk("ack1 ovalid", {15'h0, out_valid}, 16'h1);
        chk("ack1 ea", out_ea, 16'h1357);
        tick();

        // Asynchronous reset during a pending read.
        issue(16'h3100, 1'b1, 1'b0);
        chk("rstmid req", {15'h0, mem_req}, 16'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid mem_req", {15'h0, mem_req}, 16'h0);
        chk("rstmid out_valid", {15'h0, out_valid}, 16'h0);
        chk("rstmid in_ready", {15'h0, in_ready}, 16'h1);
        #1 rst_n = 1'b1;
        tick();
        issue(16'h0042, 1'b0, 1'b0);
        chk("post rst ovalid", {15'h0, out_valid}, 16'h1);
        chk("post rst ea", out_ea, 16'h0042);
        tick();

        // User-mode pointer at 0x0200: reported without a read when checking is built.
        issue(16'h0200, 1'b1, 1'b1);
        chk("acv1 mem_req", {15'h0, mem_req}, r_acv_en ? 16'h0 : 16'h1);
        chk("acv1 ovalid", {15'h0, out_valid}, r_acv_en ? 16'h1 : 16'h0);
        if (mem_req) begin
            mem_ack = 1'b1; mem_rdata = 16'h0200;
            tick();
            mem_ack = 1'b0;
        end
        chk("acv1 acv", {15'h0, acv}, r_acv_en ? 16'h1 : 16'h0);
        chk("acv1 ea", out_ea, 16'h0200);
        tick();

        issue(16'h0200, 1'b1, 1'b0);
        chk("acv0 mem_req", {15'h0, mem_req}, 16'h1);
        mem_ack = 1'b1; mem_rdata = 16'h4000;
        tick();
        mem_ack = 1'b0;
        chk("acv0 acv", {15'h0, acv}, 16'h0);
        chk("acv0 ea", out_ea, 16'h4000);
        tick();

        // Legal user pointer address whose fetched target lands in device space.
        issue(16'h3000, 1'b1, 1'b1);
        chk("acvp mem_req", {15'h0, mem_req}, 16'h1);
        mem_ack = 1'b1; mem_rdata = 16'hFE00;
        tick();
        mem_ack = 1'b0;
        chk("acvp acv", {15'h0, acv}, r_acv_en ? 16'h1 : 16'h0);
        chk("acvp ea", out_ea, 16'hFE00);
        tick();

        $display("%0d/%0d checks passed", r_pass, r_total);
        $finish;
    end

endmodule
`default_nettype wire
